// File: rtl/vd_symbol_sequencer.sv
// Input sequencer for VITERBIDECODER: buffers code symbols, strips the preamble and paces symbols
// onto a SYM_CYCLES slot grid. Define VD_TAIL_FLUSH_EN to append TAIL_LEN zero symbols per frame.
module vd_symbol_sequencer #(
    parameter int unsigned WD_CODE    = 2,
    parameter int unsigned SYM_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAIL_LEN   = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               CLOCK,
    input  logic               Reset,
    input  logic               InValid,
    input  logic [WD_CODE-1:0] InCode,
    input  logic               InLast,
    output logic               InReady,
    input  logic               Clear,
    output logic               Active,
    output logic [WD_CODE-1:0] Code,
    output logic               SymStrobe,
    output logic               Busy,
    output logic [CNT_W-1:0]   SymCount,
    output logic               Overflow,
    output logic               Underrun
);
    localparam int unsigned SLOT_W = $clog2(SYM_CYCLES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SYM_CYCLES - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef VD_TAIL_FLUSH_EN
    localparam int unsigned TAIL_W = (TAIL_LEN > 0) ? $clog2(TAIL_LEN + 1) : 1;
    localparam logic [TAIL_W-1:0] TAIL_DONE = TAIL_W'(TAIL_LEN);
    typedef enum logic [1:0] {StIdle, StRun, StTail} state_e;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              run_done;
    assign run_done = 1'b0;
`else
    typedef enum logic [1:0] {StIdle, StRun} state_e;
    logic        done_q, done_d;
    logic        run_done;
    logic [31:0] unused_tail_len;
    assign run_done        = done_q;
    assign unused_tail_len = TAIL_LEN;
`endif

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d, slot_next;
    logic [WD_CODE-1:0] code_q, code_d;
    logic               strobe_q, strobe_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               udr_q, udr_d, underrun_set;
    logic               blocked_q, blocked_d;
    logic               alive_q;

    // Each entry carries the InLast tag above the code bits.
    logic [WD_CODE:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     fill_q;
    logic               push, pop, fifo_empty, fifo_full;
    logic [WD_CODE:0]   head;

    assign fifo_full  = fill_q == FIFO_FULL;
    assign fifo_empty = fill_q == '0;
    assign head       = fifo_mem[rd_ptr_q];
    assign InReady    = alive_q & ~fifo_full & ~blocked_q;
    // Zero symbols offered in IDLE are preamble: accepted but never stored.
    assign push       = InValid & InReady & ((state_q != StIdle) | (InCode != '0));
    assign slot_next  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        code_d       = code_q;
        strobe_d     = 1'b0;
        active_d     = active_q;
        count_d      = count_q;
        blocked_d    = blocked_q | (push & InLast);
        pop          = 1'b0;
        underrun_set = 1'b0;
`ifdef VD_TAIL_FLUSH_EN
        tail_d       = tail_q;
`else
        done_d       = done_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = StRun;
                    slot_d  = '0;
                    count_d = '0;
                end
            end
            StRun: begin
                slot_d = slot_next;
                if (slot_q == '0) begin
                    if (run_done) begin
                        state_d = StIdle;
                    end else begin
                        strobe_d = 1'b1;
                        active_d = 1'b1;
                        count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            code_d = head[WD_CODE-1:0];
                            if (head[WD_CODE]) begin
`ifdef VD_TAIL_FLUSH_EN
                                state_d = StTail;
                                tail_d  = '0;
`else
                                done_d  = 1'b1;
`endif
                            end
                        end else begin
                            code_d       = '0;
                            underrun_set = 1'b1;
                        end
                    end
                end
            end
`ifdef VD_TAIL_FLUSH_EN
            StTail: begin
                slot_d = slot_next;
                if (slot_q == '0) begin
                    if (tail_q == TAIL_DONE) begin
                        state_d = StIdle;
                    end else begin
                        strobe_d = 1'b1;
                        code_d   = '0;
                        tail_d   = tail_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle && state_q != StIdle) begin
            active_d  = 1'b0;
            code_d    = '0;
            blocked_d = 1'b0;
`ifndef VD_TAIL_FLUSH_EN
            done_d    = 1'b0;
`endif
        end

        ovf_d = Clear ? 1'b0 : (ovf_q | (InValid & ~InReady));
        udr_d = Clear ? 1'b0 : (udr_q | underrun_set);
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            code_q    <= '0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
            blocked_q <= 1'b0;
            alive_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
`ifdef VD_TAIL_FLUSH_EN
            tail_q    <= '0;
`else
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            code_q    <= code_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
            blocked_q <= blocked_d;
            alive_q   <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      fill_q <= fill_q + 1'b1;
            else if (pop && !push) fill_q <= fill_q - 1'b1;
`ifdef VD_TAIL_FLUSH_EN
            tail_q    <= tail_d;
`else
            done_q    <= done_d;
`endif
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) fifo_mem[wr_ptr_q] <= {InLast, InCode};
    end

    assign Active    = active_q;
    assign Code      = code_q;
    assign SymStrobe = strobe_q;
    assign Busy      = state_q != StIdle;
    assign SymCount  = count_q;
    assign Overflow  = ovf_q;
    assign Underrun  = udr_q;

endmodule

// File: tb/tb_vd_symbol_sequencer.sv
// Directed self-checking bench for vd_symbol_sequencer; a second CNT_W=4 instance covers saturation.
module tb_vd_symbol_sequencer;
    localparam int SYMC = 8;
`ifdef VD_TAIL_FLUSH_EN
    localparam int TAILN = 8;
`else
    localparam int TAILN = 0;
`endif

    logic       CLOCK = 1'b0;
    logic       Reset = 1'b0;
    logic       InValid = 1'b0;
    logic [1:0] InCode = 2'd0;
    logic       InLast = 1'b0;
    logic       Clear = 1'b0;
    logic       InReady, Active, SymStrobe, Busy, Overflow, Underrun;
    logic [1:0] Code;
    logic [15:0] SymCount;

    logic       s_valid = 1'b0;
    logic [1:0] s_code_in = 2'd0;
    logic       s_last = 1'b0;
    logic       s_ready, s_active, s_strobe, s_busy, s_ovf, s_udr;
    logic [1:0] s_code;
    logic [3:0] s_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [1:0] sq[$];
    int         sc[$];
    logic [1:0] exp_q[$];

    vd_symbol_sequencer dut (
        .CLOCK(CLOCK), .Reset(Reset), .InValid(InValid), .InCode(InCode), .InLast(InLast),
        .InReady(InReady), .Clear(Clear), .Active(Active), .Code(Code), .SymStrobe(SymStrobe),
        .Busy(Busy), .SymCount(SymCount), .Overflow(Overflow), .Underrun(Underrun)
    );

    vd_symbol_sequencer #(.CNT_W(4)) dut_sat (
        .CLOCK(CLOCK), .Reset(Reset), .InValid(s_valid), .InCode(s_code_in), .InLast(s_last),
        .InReady(s_ready), .Clear(1'b0), .Active(s_active), .Code(s_code), .SymStrobe(s_strobe),
        .Busy(s_busy), .SymCount(s_count), .Overflow(s_ovf), .Underrun(s_udr)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;
    always @(negedge CLOCK) begin
        if (SymStrobe === 1'b1) begin
            sq.push_back(Code);
            sc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [1:0] c, input logic l);
        InValid = 1'b1;
        InCode  = c;
        InLast  = l;
        tick();
        InValid = 1'b0;
        InLast  = 1'b0;
        InCode  = 2'd0;
    endtask

    task automatic wait_idle(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            tick();
            n++;
            if (Busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        Reset = 1'b0;
        ticks(2);
        obs = {InReady, Active, Code, SymStrobe, Busy, Overflow, Underrun};
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000", obs);
        end
        checks++;
        if (SymCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_symcount got %0d want 0", SymCount);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (InReady !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b want 1 0", InReady, Busy);
        end
    endtask

    task automatic test_preamble();
        int n, bad;
        bit ok;
        sq.delete();
        sc.delete();
        push(2'd0, 1'b0); ticks(7);
        push(2'd0, 1'b0); ticks(7);
        checks++;
        if (Busy !== 1'b0 || sq.size() != 0) begin
            errors++;
            $display("FAIL preamble_discard got busy=%b strobes=%0d want 0 0", Busy, sq.size());
        end
        push(2'd3, 1'b0);
        checks++;
        if (Busy !== 1'b1 || Active !== 1'b0 || SymStrobe !== 1'b0) begin
            errors++;
            $display("FAIL first_accept got busy=%b active=%b strobe=%b want 1 0 0",
                     Busy, Active, SymStrobe);
        end
        tick();
        checks++;
        if (Active !== 1'b1 || SymStrobe !== 1'b1 || Code !== 2'd3 || SymCount !== 16'd1) begin
            errors++;
            $display("FAIL first_strobe got active=%b strobe=%b code=%0d cnt=%0d want 1 1 3 1",
                     Active, SymStrobe, Code, SymCount);
        end
        tick();
        checks++;
        if (SymStrobe !== 1'b0 || Code !== 2'd3) begin
            errors++;
            $display("FAIL code_hold got strobe=%b code=%0d want 0 3", SymStrobe, Code);
        end
        ticks(5);
        push(2'd2, 1'b0); ticks(7);
        push(2'd3, 1'b0); ticks(7);
        push(2'd0, 1'b0); ticks(7);
        push(2'd2, 1'b1);
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL last_blocks_ready got %b want 0", InReady);
        end
        wait_idle(300, n, ok);
        checks++;
        if (!ok || n != 9 + SYMC * TAILN) begin
            errors++;
            $display("FAIL frame_end_cycles got ok=%0d n=%0d want 1 %0d", ok, n, 9 + SYMC * TAILN);
        end
        checks++;
        if (Active !== 1'b0 || Code !== 2'd0 || SymCount !== 16'd5) begin
            errors++;
            $display("FAIL frame_end_state got active=%b code=%0d cnt=%0d want 0 0 5",
                     Active, Code, SymCount);
        end
        checks++;
        if (sc.size() == 0 || cyc - sc[sc.size()-1] != SYMC) begin
            errors++;
            $display("FAIL active_fall_delay got %0d want %0d",
                     (sc.size() == 0) ? -1 : cyc - sc[sc.size()-1], SYMC);
        end
        exp_q = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd2};
        for (int i = 0; i < TAILN; i++) exp_q.push_back(2'd0);
        checks++;
        if (sq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL preamble_strobes got %0d want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL preamble_code[%0d] got %0d want %0d", i, sq[i], exp_q[i]);
                end
            end
        end
        bad = 0;
        for (int i = 1; i < sc.size(); i++) if (sc[i] - sc[i-1] != SYMC) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL strobe_grid got %0d off-grid want 0", bad);
        end
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        sq.delete();
        sc.delete();
        InValid = 1'b1;
        InCode = 2'd1; tick();
        InCode = 2'd2; tick();
        InCode = 2'd3; tick();
        InCode = 2'd1; tick();
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ready_at3 got %b want 1", InReady);
        end
        InCode = 2'd2; tick();
        checks++;
        if (InReady !== 1'b0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got ready=%b ovf=%b want 0 0", InReady, Overflow);
        end
        InCode = 2'd3; tick();
        InValid = 1'b0;
        checks++;
        if (Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", Overflow);
        end
        n = 0;
        while (InReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ready_return got %b want 1", InReady);
        end
        push(2'd3, 1'b1);
        wait_idle(300, n, ok);
        checks++;
        if (!ok || SymCount !== 16'd6 || Underrun !== 1'b0) begin
            errors++;
            $display("FAIL ovf_frame got ok=%0d cnt=%0d udr=%b want 1 6 0", ok, SymCount, Underrun);
        end
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < TAILN; i++) exp_q.push_back(2'd0);
        checks++;
        if (sq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_strobes got %0d want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ovf_code[%0d] got %0d want %0d", i, sq[i], exp_q[i]);
                end
            end
        end
        Clear = 1'b1; tick(); Clear = 1'b0;
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", Overflow);
        end
    endtask

    task automatic test_underrun();
        int n;
        bit ok;
        sq.delete();
        sc.delete();
        push(2'd3, 1'b0);
        ticks(20);
        push(2'd1, 1'b1);
        wait_idle(300, n, ok);
        checks++;
        if (!ok || Underrun !== 1'b1 || SymCount !== 16'd4) begin
            errors++;
            $display("FAIL udr_frame got ok=%0d udr=%b cnt=%0d want 1 1 4", ok, Underrun, SymCount);
        end
        exp_q = '{2'd3, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < TAILN; i++) exp_q.push_back(2'd0);
        checks++;
        if (sq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL udr_strobes got %0d want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL udr_code[%0d] got %0d want %0d", i, sq[i], exp_q[i]);
                end
            end
        end
        Clear = 1'b1; tick(); Clear = 1'b0;
        checks++;
        if (Underrun !== 1'b0) begin
            errors++;
            $display("FAIL udr_clear got %b want 0", Underrun);
        end
    endtask

    task automatic test_reset_midframe();
        int n, n0;
        bit ok;
        logic [7:0] obs;
        sq.delete();
        sc.delete();
        InValid = 1'b1;
        InCode = 2'd1; tick();
        InCode = 2'd2; tick();
        InCode = 2'd3; tick();
        InCode = 2'd1; tick();
        InValid = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Active !== 1'b1) begin
            errors++;
            $display("FAIL mid_running got busy=%b active=%b want 1 1", Busy, Active);
        end
        #2 Reset = 1'b0;
        #1;
        obs = {InReady, Active, Code, SymStrobe, Busy, Overflow, Underrun};
        checks++;
        if (obs !== 8'h00 || SymCount !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b cnt=%0d want 00000000 0", obs, SymCount);
        end
        n0 = sq.size();
        ticks(3);
        Reset = 1'b1;
        ticks(20);
        checks++;
        if (sq.size() != n0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_strobes got strobes=%0d busy=%b want %0d 0", sq.size(), Busy, n0);
        end
        sq.delete();
        sc.delete();
        push(2'd2, 1'b1);
        wait_idle(300, n, ok);
        checks++;
        if (!ok || SymCount !== 16'd1 || sq.size() != 1 + TAILN) begin
            errors++;
            $display("FAIL mid_next_frame got ok=%0d cnt=%0d strobes=%0d want 1 1 %0d",
                     ok, SymCount, sq.size(), 1 + TAILN);
        end else begin
            checks++;
            if (sq[0] !== 2'd2) begin
                errors++;
                $display("FAIL mid_next_code got %0d want 2", sq[0]);
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int i = 0; i < 20; i++) begin
            s_valid   = 1'b1;
            s_code_in = 2'((i % 3) + 1);
            s_last    = (i == 19);
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i == 10) begin
                checks++;
                if (s_count !== 4'd10) begin
                    errors++;
                    $display("FAIL sat_midcount got %0d want 10", s_count);
                end
            end
            if (i < 19) ticks(7);
        end
        n = 0;
        while (s_busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (s_busy !== 1'b0 || s_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_count got busy=%b cnt=%0d want 0 15", s_busy, s_count);
        end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_overflow();
        test_underrun();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vd_symbol_sequencer.md
# vd_symbol_sequencer

Input sequencer for the Viterbi decoder. Takes encoder code symbols through a valid/ready handshake, buffers them in a small FIFO, detects start of frame, and paces them out at one symbol per `SYM_CYCLES` decoder clocks. It drives `Active`, `Code` and a symbol strobe into `VITERBIDECODER`. It replaces the ad-hoc `Active` synchroniser and appends the zero tail that terminates the K=9 trellis.

## Interface
- `WD_CODE`, 2, code symbol width (matches `` `WD_CODE ``)
- `SYM_CYCLES`, 8, decoder clocks per symbol slot; legal range ≥ 2
- `FIFO_DEPTH`, 4, input FIFO entries; power of 2, ≥ 2
- `TAIL_LEN`, 8, zero symbols appended after the frame end (K−1)
- `CNT_W`, 16, symbol counter width

- `CLOCK`  in  1  decoder clock; all state on the rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `InValid`  in  1  input symbol valid
- `InCode`  in  WD_CODE  input symbol
- `InLast`  in  1  marks the last symbol of the frame; qualified by `InValid`
- `InReady`  out  1  FIFO can accept a symbol
- `Clear`  in  1  synchronous clear of the sticky flags
- `Active`  out  1  decoder enable
- `Code`  out  WD_CODE  symbol presented to the decoder
- `SymStrobe`  out  1  one-cycle pulse when `Code` updates
- `Busy`  out  1  state ≠ IDLE
- `SymCount`  out  CNT_W  frame symbols emitted; saturating
- `Overflow`  out  1  sticky: symbol offered while `InReady`=0
- `Underrun`  out  1  sticky: slot fired with the FIFO empty in RUN

## Operation
- **FSM states:** IDLE, RUN, TAIL.
- **IDLE**
  - `InReady`=1.
  - Accepted symbols with `InCode`=0 are discarded; this is the preamble.
  - The first accepted symbol ≠ 0 is pushed and the FSM moves to RUN.
  - `SymCount` and the slot counter are cleared on that transition.
- **RUN**
  - The slot counter counts 0..SYM_CYCLES−1 and wraps.
  - At slot 0:
    - FIFO non-empty: pop into `Code`, pulse `SymStrobe`, increment `SymCount`.
    - FIFO empty: `Code`←0, pulse `SymStrobe`, increment `SymCount`, set `Underrun`.
  - When the popped entry carries the `InLast` tag, the FSM moves to TAIL; with the macro off it moves to IDLE.
- **TAIL**
  - Emits `TAIL_LEN` slots with `Code`=0 and a `SymStrobe` each; `SymCount` is not incremented.
  - After the last tail slot, the FSM moves to IDLE.
- **Handshake**
  - Push occurs when `InValid & InReady`.
  - `InReady` = !full, and 0 from the cycle after an `InLast` symbol is accepted until the FSM returns to IDLE.
  - `InValid & !InReady` drops the symbol and sets `Overflow`.
  - In RUN, push and pop in the same cycle are both performed; occupancy is unchanged.
  - When the FIFO is full, `InReady` is low, so the same-cycle pop does not admit a push that cycle.
- **Active**
  - Set on the first `SymStrobe` of a frame.
  - Cleared on the cycle the FSM enters IDLE.
- `Code` holds its value between strobes.
- `Code` is forced to 0 in IDLE.
- **Sticky flags:** cleared by `Clear` or reset. `Clear` has priority over a same-cycle set.
- `SymCount` saturates at 2^CNT_W−1.

## Timing
- **Reset values:**
  - `InReady`=0 while `Reset`=0, 1 after release.
  - All other outputs = 0.
  - FIFO is empty.
  - FSM is in IDLE.
- **Reset mid-frame:** immediate return to reset values. FIFO contents are lost and no tail is emitted.
- **First-symbol latency:**
  - The first nonzero symbol is accepted at edge k.
  - `Code`/`SymStrobe`/`Active` are valid after edge k+1.
  - Subsequent strobes occur at k+1+n·SYM_CYCLES.
- **Last-symbol timing:**
  - Tail strobes continue on the same slot grid.
  - `Busy`/`Active` fall on the edge that ends the final tail slot period, SYM_CYCLES cycles after the last tail strobe.
- All outputs are registered; there is no combinational path from inputs to outputs except `InReady`'s dependence on state/occupancy.

## Configuration
- `VD_TAIL_FLUSH_EN`
  - **Defined:** TAIL state is present and `TAIL_LEN` zero symbols are appended after `InLast`.
  - **Undefined:** TAIL is absent. The last frame symbol's slot completes, then the FSM enters IDLE and `Active` drops. `TAIL_LEN` is ignored.

## Test plan
- **Preamble and first symbol:** after reset release, push 00,00,11 one per 8 clocks, then 10,11,00,10 with `InLast` on the final one. Required: `Active`=1 one cycle after 11 is accepted; `Code` sequence 11,10,11,00,10, then eight 00 tail strobes; `SymCount`=5; `Busy`=0 afterwards.
- **Overflow:** with defaults, push 6 symbols back-to-back in consecutive cycles. Required: `InReady` low after 4 occupied; 1 dropped; `Overflow`=1; emitted order matches accepted order. A following `Clear` pulse gives `Overflow`=0.
- **Underrun:** start a frame with 11, then wait 20 clocks before the next push. Required: two zero-code strobes, `Underrun`=1, `SymCount` includes them.
- **Reset mid-frame:** assert `Reset` during RUN with 3 symbols queued. Required: all outputs 0 in the same cycle; no further strobes; the next frame decodes normally.
- **Macro off:** repeat the first scenario without `VD_TAIL_FLUSH_EN`. Required: no tail strobes; `Active` falls 8 clocks after the 10 strobe.
- **Saturation:** with `CNT_W`=4, run a 20-symbol frame. Required: `SymCount` holds 15.
